// File: rtl/io_map_pkg.sv
// Shared IO region map: region tag, register offsets and status bit positions.
// Also consumed by the core's s3 read mux.
package io_map_pkg;

    localparam logic [1:0] IO_REGION     = 2'b10;

    localparam logic [7:0] OFF_STATUS    = 8'h00;
    localparam logic [7:0] OFF_RX_DATA   = 8'h04;
    localparam logic [7:0] OFF_TX_DATA   = 8'h08;
    localparam logic [7:0] OFF_CYC_CNT   = 8'h10;
    localparam logic [7:0] OFF_INSTR_CNT = 8'h14;
    localparam logic [7:0] OFF_CNT_CLR   = 8'h18;

    localparam int STAT_TX_SPACE = 0;
    localparam int STAT_RX_VALID = 1;

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic [7:0] off;
    } io_req_t;

    function automatic logic io_sel(input logic [31:0] a);
        return a[31:30] == IO_REGION;
    endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Parameterised synchronous FIFO for the UART tx path; head entry is read
// straight from the storage flops.
module io_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]             cnt_q, cnt_d;
    logic                    push_ok, pop_ok;

    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign dout  = mem_q[rd_ptr_q];

    // Fullness is judged before the edge, so a push against a full FIFO is
    // dropped even if the head pops in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok)
            rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/mmio_io_responder.sv
// MMIO target for the 0x8000_0000 IO region: UART tx/rx, cycle/instruction counters.
// Define IO_TX_FIFO_EN to replace the single tx holding register with io_tx_fifo.
module mmio_io_responder
    import io_map_pkg::*;
#(
    parameter int TX_FIFO_DEPTH = 4,
    parameter int CNT_W         = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic        instr_retire,
    output logic [31:0] rdata,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);
    if (TX_FIFO_DEPTH < 2 || (TX_FIFO_DEPTH & (TX_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("TX_FIFO_DEPTH must be a power of two >= 2");
    end
    if (CNT_W != 32) begin : g_bad_cnt_w
        $error("CNT_W must be 32 for the register map");
    end

    io_req_t          req;
    logic             tx_wr, tx_pop, tx_space, cnt_clr;
    logic [CNT_W-1:0] cyc_q, cyc_d, ins_q, ins_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             unused_ok;

    assign unused_ok = ^{addr[29:8], wdata[31:8]};

    assign req.rd  = re && io_sel(addr);
    assign req.wr  = we && io_sel(addr);
    assign req.off = addr[7:0];

    assign tx_wr   = req.wr && req.off == OFF_TX_DATA;
    assign cnt_clr = req.wr && req.off == OFF_CNT_CLR;
    assign tx_pop  = uart_tx_valid && uart_tx_ready;

    // Held low through reset so no rx byte is lost while the core is down.
    assign uart_rx_ready = rst_n && req.rd && req.off == OFF_RX_DATA;

`ifdef IO_TX_FIFO_EN
    logic tx_full, tx_empty;

    io_tx_fifo #(.DEPTH(TX_FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_wr),
        .din   (wdata[7:0]),
        .pop   (tx_pop),
        .dout  (uart_tx_data),
        .full  (tx_full),
        .empty (tx_empty)
    );

    assign uart_tx_valid = !tx_empty;
    assign tx_space      = !tx_full;
`else
    logic       tx_valid_q, tx_valid_d;
    logic [7:0] tx_data_q, tx_data_d;

    // tx_space is the pre-edge view, so a store landing on the handshake edge is dropped.
    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (tx_wr && tx_space) begin
            tx_valid_d = 1'b1;
            tx_data_d  = wdata[7:0];
        end else if (tx_pop) begin
            tx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign uart_tx_valid = tx_valid_q;
    assign uart_tx_data  = tx_data_q;
    assign tx_space      = !tx_valid_q;
`endif

    always_comb begin
        cyc_d = cnt_clr ? '0 : cyc_q + 1'b1;
        ins_d = cnt_clr ? '0 : ins_q + CNT_W'(instr_retire);
    end

    // Read mux sees pre-edge state, so a same-cycle store is invisible to the load.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = '0;
            if (req.rd) begin
                case (req.off)
                    OFF_STATUS: begin
                        rdata_d[STAT_TX_SPACE] = tx_space;
                        rdata_d[STAT_RX_VALID] = uart_rx_valid;
                    end
                    OFF_RX_DATA:   if (uart_rx_valid) rdata_d = {24'b0, uart_rx_data};
                    OFF_CYC_CNT:   rdata_d = cyc_q;
                    OFF_INSTR_CNT: rdata_d = ins_q;
                    default:       rdata_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q   <= '0;
            ins_q   <= '0;
            rdata_q <= '0;
        end else begin
            cyc_q   <= cyc_d;
            ins_q   <= ins_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_mmio_io_responder.sv
// Scoreboard bench for mmio_io_responder: a behavioural model queues expected
// load data at each load edge; outputs are sampled 1 time unit after the edge.
module tb_mmio_io_responder;
`ifdef IO_TX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk, rst_n;
    logic [31:0] addr, wdata, rdata;
    logic        we, re, instr_retire;
    logic [7:0]  uart_tx_data, uart_rx_data;
    logic        uart_tx_valid, uart_tx_ready, uart_rx_valid, uart_rx_ready;

    mmio_io_responder #(.TX_FIFO_DEPTH(4), .CNT_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .addr          (addr),
        .wdata         (wdata),
        .we            (we),
        .re            (re),
        .instr_retire  (instr_retire),
        .rdata         (rdata),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model
    logic [31:0] m_cyc, m_ins;
    logic [7:0]  m_fifo[$];
    logic [31:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin : mdl
        logic [31:0] e;
        int          sz;
        if (!rst_n) begin
            m_cyc <= 0;
            m_ins <= 0;
            m_fifo.delete();
            exp_q.delete();
        end else begin
            sz = m_fifo.size();
            e  = 0;
            if (re && addr[31:30] == 2'b10) begin
                case (addr[7:0])
                    8'h00: e = {30'b0, uart_rx_valid, sz < DEPTH};
                    8'h04: e = uart_rx_valid ? {24'b0, uart_rx_data} : 0;
                    8'h10: e = m_cyc;
                    8'h14: e = m_ins;
                    default: e = 0;
                endcase
            end
            if (re) exp_q.push_back(e);
            if (sz > 0 && uart_tx_ready) void'(m_fifo.pop_front());
            if (we && addr[31:30] == 2'b10 && addr[7:0] == 8'h08 && sz < DEPTH)
                m_fifo.push_back(wdata[7:0]);
            if (we && addr[31:30] == 2'b10 && addr[7:0] == 8'h18) begin
                m_cyc <= 0;
                m_ins <= 0;
            end else begin
                m_cyc <= m_cyc + 1;
                m_ins <= m_ins + {31'b0, instr_retire};
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) chk("rdata", rdata, exp_q.pop_front());
    endtask

    task automatic chk_tx(input string tag);
        chk({tag, "_valid"}, {31'b0, uart_tx_valid}, {31'b0, m_fifo.size() > 0});
        if (m_fifo.size() > 0) chk({tag, "_data"}, {24'b0, uart_tx_data}, {24'b0, m_fifo[0]});
    endtask

    task automatic rd(input logic [31:0] a);
        addr = a; re = 1'b1;
        step();
        re = 1'b0;
        step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        step();
        we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; addr = 0; wdata = 0; we = 0; re = 0; instr_retire = 0;
        uart_tx_ready = 0; uart_rx_data = 0; uart_rx_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 0);
        chk("rst_tx_valid", {31'b0, uart_tx_valid}, 0);
        chk("rst_tx_data", {24'b0, uart_tx_data}, 0);
        rst_n = 1'b1;

        // 1: counters after 10 cycles
        repeat (10) step();
        addr = 32'h8000_0010; re = 1'b1;
        step();
        re = 1'b0;
        chk("cyc_after_10", rdata, 32'd10);
        rd(32'h8000_0014);

        // 2: tx holding / drop when no space
        wr(32'h8000_0008, 32'h41);
        chk_tx("tx_first");
        chk("tx_first_data", {24'b0, uart_tx_data}, 32'h41);
        rd(32'h8000_0000);
        wr(32'h8000_0008, 32'h42);
        chk("tx_head_kept", {24'b0, uart_tx_data}, 32'h41);
        chk_tx("tx_second");
        uart_tx_ready = 1'b1;
        step();
        uart_tx_ready = 1'b0;
        chk_tx("tx_after_hs");
        rd(32'h8000_0000);
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 8 && m_fifo.size() > 0; i++) step();
        uart_tx_ready = 1'b0;
        chk("tx_drained", {31'b0, uart_tx_valid}, 0);

        // store during handshake edge is dropped (single-entry build fills first)
        wr(32'h8000_0008, 32'h33);
        uart_tx_ready = 1'b1;
        wr(32'h8000_0008, 32'h34);
        uart_tx_ready = 1'b0;
        chk_tx("tx_hs_store");
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 8 && m_fifo.size() > 0; i++) step();
        uart_tx_ready = 1'b0;

        // re+we same cycle: status reflects pre-store space
        addr = 32'h8000_0008; wdata = 32'h99; we = 1'b1; re = 1'b1;
        step();
        we = 1'b0; re = 1'b0;
        step();
        chk_tx("tx_rw_same");
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 8 && m_fifo.size() > 0; i++) step();
        uart_tx_ready = 1'b0;

        // 3: rx path
        uart_rx_valid = 1'b1; uart_rx_data = 8'h5A;
        addr = 32'h8000_0000; re = 1'b1;
        #1 chk("rx_ready_status", {31'b0, uart_rx_ready}, 0);
        step();
        re = 1'b0;
        addr = 32'h8000_0004; re = 1'b1;
        #1 chk("rx_ready_pulse", {31'b0, uart_rx_ready}, 1);
        step();
        re = 1'b0;
        #1 chk("rx_ready_low", {31'b0, uart_rx_ready}, 0);
        chk("rx_byte", rdata, 32'h5A);
        uart_rx_valid = 1'b0;
        rd(32'h8000_0004);

        // 4: counter clear beats same-cycle retire
        instr_retire = 1'b1;
        repeat (7) step();
        wr(32'h8000_0018, 0);
        instr_retire = 1'b0;
        addr = 32'h8000_0010; re = 1'b1;
        step();
        re = 1'b0;
        chk("cyc_cleared", rdata, 0);
        rd(32'h8000_0014);
        chk("ins_cleared", rdata, 0);
        instr_retire = 1'b1;
        repeat (3) step();
        instr_retire = 1'b0;
        rd(32'h8000_0014);
        chk("ins_recount", rdata, 3);

        // 5: unmapped offsets and out-of-region
        rd(32'h8000_0040);
        rd(32'h4000_0010);
        wr(32'h8000_003C, 32'h55);
        wr(32'h0000_0008, 32'h66);
        chk_tx("unmapped_store");
        rd(32'h8000_0014);

`ifdef IO_TX_FIFO_EN
        // 6: FIFO fill, overflow drop, ordered drain
        for (int i = 1; i <= 5; i++) wr(32'h8000_0008, i);
        chk_tx("fifo_full");
        rd(32'h8000_0000);
        uart_tx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("fifo_order", {24'b0, uart_tx_data}, i);
            step();
        end
        chk("fifo_empty", {31'b0, uart_tx_valid}, 0);
        uart_tx_ready = 1'b0;
        for (int i = 1; i <= 3; i++) wr(32'h8000_0008, 32'h10 + i);
        uart_tx_ready = 1'b1;
        step();
        chk_tx("fifo_mid_drain");
`else
        wr(32'h8000_0008, 32'h77);
        chk_tx("tx_pre_reset");
`endif
        // async reset mid-transfer drops the byte; no rx consumption in reset
        uart_rx_valid = 1'b1;
        addr = 32'h8000_0004; re = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_tx_drop", {31'b0, uart_tx_valid}, 0);
        chk("rst_rx_ready", {31'b0, uart_rx_ready}, 0);
        re = 1'b0; uart_rx_valid = 1'b0; uart_tx_ready = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk_tx("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
